keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and debounces key presses.
- Drives the keypad columns active-low, one at a time, and reads the active-low rows.
- Decodes each debounced press into a 4-bit key value and shifts digit keys into a 4-digit buffer.
- The buffer outputs connect straight to the four digit inputs of the 7-segment display driver, so the board echoes typed digits (input side of the keypad/display user interface).

Parameters:
- SCAN_DIV, 100000: clk cycles per column slot (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_CNT, 20: consecutive matching slot samples required for press and for release; minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- row_n  in  4  keypad rows, active-low, asynchronous to clk
- col_n  out  4  keypad column drive, active-low, exactly one bit low
- key_code  out  4  decoded value of the last accepted key
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high from acceptance until release is confirmed
- num1..num4  out  4 each  digit buffer; num1 is the newest digit (rightmost); 4'hF means blank

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - col_n = 4'b1110
  - key_code = 0, key_valid = 0, key_held = 0
  - num1..num4 = 4'hF
  - FSM = SCAN, slot counter = 0, debounce counter = 0
  - Synchronizer flops = 4'b1111
- Synchronizer: row_n passes through a 2-FF synchronizer before use.
- Slot timing:
  - The slot counter runs 0..SCAN_DIV-1 and wraps.
  - Rows are sampled only on the cycle the counter equals SCAN_DIV-1 (the "slot end"), giving settle time.
  - Candidate row = lowest-index row that reads low. "None" means all rows read high.
- FSM state SCAN:
  - At slot end with no row low: rotate col_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - At slot end with a row low: latch cand_col and cand_row, set count = 1, go to DEBOUNCE. col_n does not rotate.
- FSM state DEBOUNCE:
  - col_n stays on cand_col.
  - At slot end, if the same candidate row is low: count++.
  - When count reaches DEBOUNCE_CNT: key_code <= KEY_MAP[{cand_row, cand_col}], key_valid = 1 for exactly one cycle, key_held <= 1, go to HELD.
  - Any other sample (none low, or a different lowest row): go to SCAN, rotate column, no output.
- FSM state HELD:
  - col_n stays on cand_col.
  - At slot end, if cand_row reads high: release count++. If it reads low: release count = 0.
  - When release count reaches DEBOUNCE_CNT: key_held <= 0, go to SCAN, rotate column.
  - No further key_valid pulses while in HELD (no auto-repeat). Other keys are ignored.
- Press latency: from stable contact to key_valid is 2 synchronizer cycles plus up to DEBOUNCE_CNT+4 slots.
- KEY_MAP (row-major, row 0 first):
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: E 0 F D
- Digit buffer update, on the cycle after key_valid:
  - Value 0..9: num4 <= num3, num3 <= num2, num2 <= num1, num1 <= value.
  - 4'hB (backspace): num1 <= num2, num2 <= num3, num3 <= num4, num4 <= 4'hF.
  - 4'hC (clear): all four digits <= 4'hF.
  - Any other value: buffer unchanged.
- Reset mid-operation: asserting rst_n low at any point returns all outputs and state to their reset values immediately, without waiting for a clock edge. After release, scanning restarts at column 0 slot 0.

Decomposition:
- Shared package keypad_pkg:
  - KEY_MAP constant array (16 x 4 bits)
  - KEY_BACK = 4'hB, KEY_CLEAR = 4'hC, DIGIT_BLANK = 4'hF
  - FSM state enum {SCAN, DEBOUNCE, HELD}
- One sub-module, digit_buffer:
  - Inputs: clk, rst_n, key_code, key_valid.
  - Outputs: num1..num4.
  - Contains the shift, backspace and clear logic.
- Scanner FSM, slot counter and synchronizer stay in keypad_scan.

Test Plan (all scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3):
1. Reset, no keys pressed -> col_n cycles 1110, 1101, 1011, 0111, 1110 with a 4-clk period per column; key_valid never asserts; num1..num4 = F,F,F,F.
2. Hold row 1 low while col 2 is driven (key 6), release after 20 slots -> exactly one key_valid pulse with key_code = 6; key_held high until 3 high samples; then num1 = 6, num2..num4 = F.
3. Press 1, 2, 3, 4, 5 in sequence -> num4..num1 = 2,3,4,5 (the 1 is shifted out); then press C -> all digits F.
4. Bounce: row toggles low/high on alternate slots for 10 slots -> no key_valid; FSM returns to SCAN each time.
5. Rows 0 and 2 low together on col 0 -> key_code = 1 (lowest row wins); press B afterwards -> num1 = F after backspace.
6. Assert rst_n low while in HELD -> key_held = 0 and col_n = 1110 immediately; digits blank; after release, a new press is accepted normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, key map and scanner state encoding for the keypad front end.
package keypad_pkg;

    localparam logic [3:0] KEY_BACK    = 4'hB;
    localparam logic [3:0] KEY_CLEAR   = 4'hC;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Indexed by {row, col}; row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    // Index of the lowest-numbered bit that reads low; all-high returns 3.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        if (!v[0]) return 2'd0;
        if (!v[1]) return 2'd1;
        if (!v[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic is_digit(input logic [3:0] v);
        return (v <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_scan_digit_buffer.sv
// Four-digit entry buffer: digits shift in on the right, B backspaces, C clears.
module digit_buffer
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4
);

    // Element 0 is num1, the newest (rightmost) digit.
    logic [3:0][3:0] dig_q, dig_d;

    always_comb begin
        dig_d = dig_q;
        if (key_valid) begin
            if (is_digit(key_code)) begin
                dig_d = {dig_q[2:0], key_code};
            end else if (key_code == KEY_BACK) begin
                dig_d = {DIGIT_BLANK, dig_q[3:1]};
            end else if (key_code == KEY_CLEAR) begin
                dig_d = {4{DIGIT_BLANK}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= {4{DIGIT_BLANK}};
        end else begin
            dig_q <= dig_d;
        end
    end

    assign num1 = dig_q[0];
    assign num2 = dig_q[1];
    assign num3 = dig_q[2];
    assign num4 = dig_q[3];

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column drive, row synchronizer, slot-based debounce and key decode.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]        sync1_q, sync2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    scan_state_e       state_q, state_d;
    logic [3:0]        col_n_q, col_n_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;

    logic              slot_end;
    logic              row_any;
    logic [1:0]        row_lo;
    logic [CNT_W-1:0]  cnt_inc;
    logic [3:0]        col_rot;

    assign slot_end = (slot_q == SLOT_W'(SCAN_DIV - 1));
    assign row_any  = (sync2_q != 4'hF);
    assign row_lo   = low_index(sync2_q);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign col_rot  = {col_n_q[2:0], col_n_q[3]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        slot_d      = slot_end ? '0 : slot_q + SLOT_W'(1);
        state_d     = state_q;
        col_n_d     = col_n_q;
        cand_row_d  = cand_row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (slot_end) begin
            case (state_q)
                SCAN: begin
                    if (row_any) begin
                        cand_row_d = row_lo;
                        cnt_d      = CNT_W'(1);
                        state_d    = DEBOUNCE;
                    end else begin
                        col_n_d = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (row_any && row_lo == cand_row_q) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                            key_code_d  = KEY_MAP[{cand_row_q, low_index(col_n_q)}];
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        col_n_d = col_rot;
                    end
                end
                HELD: begin
                    // Only the held key's row matters here; other keys are ignored.
                    if (sync2_q[cand_row_q]) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = SCAN;
                            col_n_d    = col_rot;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            slot_q      <= '0;
            state_q     <= SCAN;
            col_n_q     <= 4'b1110;
            cand_row_q  <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= row_n;
            sync2_q     <= sync1_q;
            slot_q      <= slot_d;
            state_q     <= state_d;
            col_n_q     <= col_n_d;
            cand_row_q  <= cand_row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    digit_buffer u_digit_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code_q),
        .key_valid (key_valid_q),
        .num1      (num1),
        .num2      (num2),
        .num3      (num3),
        .num4      (num4)
    );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: physical keypad model, slot-level reference model, directed presses.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int WAIT_LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [3:0]  num1, num2, num3, num4;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .num1      (num1),
        .num2      (num2),
        .num3      (num3),
        .num4      (num4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (slot-level behaviour) ----------------
    localparam int M_IDLE = 0, M_BOUNCE = 1, M_DOWN = 2;
    string KEYS = "123A456B789CE0FD";

    int         m_slot, m_col, m_mode, m_cand, m_cnt, m_code;
    bit         m_valid, m_held;
    int         m_dig [4];
    logic [3:0] h1, h2;

    function automatic int hexval(input byte ch);
        return (ch <= 8'h39) ? int'(ch) - 48 : int'(ch) - 55;
    endfunction

    function automatic int lowest(input logic [3:0] s);
        for (int r = 0; r < 4; r++) if (!s[r]) return r;
        return -1;
    endfunction

    task automatic model_reset();
        m_slot = 0; m_col = 0; m_mode = M_IDLE; m_cand = 0; m_cnt = 0;
        m_code = 0; m_valid = 0; m_held = 0;
        h1 = 4'hF; h2 = 4'hF;
        for (int i = 0; i < 4; i++) m_dig[i] = 15;
    endtask

    task automatic apply_key(input int k);
        if (k <= 9) begin
            for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = k;
        end else if (k == 11) begin
            for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
            m_dig[3] = 15;
        end else if (k == 12) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 15;
        end
    endtask

    task automatic model_step(input logic [3:0] rin);
        logic [3:0] s;
        int lo;
        s  = h2;
        h2 = h1;
        h1 = rin;
        if (m_valid) apply_key(m_code);
        m_valid = 0;
        if (m_slot == SD - 1) begin
            lo = lowest(s);
            if (m_mode == M_IDLE) begin
                if (lo < 0) m_col = (m_col + 1) % 4;
                else begin m_cand = lo; m_cnt = 1; m_mode = M_BOUNCE; end
            end else if (m_mode == M_BOUNCE) begin
                if (lo == m_cand) begin
                    m_cnt++;
                    if (m_cnt == DC) begin
                        m_code = hexval(KEYS[m_cand*4 + m_col]);
                        m_valid = 1; m_held = 1; m_mode = M_DOWN; m_cnt = 0;
                    end
                end else begin
                    m_mode = M_IDLE; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (s[m_cand]) m_cnt++; else m_cnt = 0;
                if (m_cnt == DC) begin
                    m_held = 0; m_mode = M_IDLE; m_col = (m_col + 1) % 4; m_cnt = 0;
                end
            end
        end
        m_slot = (m_slot + 1) % SD;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(row_n);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [3:0] ec;
        forever begin
            @(negedge clk);
            ec = 4'hF;
            ec[m_col] = 1'b0;
            check("col_n", col_n, ec);
            check("key_valid", key_valid, m_valid);
            check("key_held", key_held, m_held);
            check("key_code", key_code, m_code);
            check("num1", num1, m_dig[0]);
            check("num2", num2, m_dig[1]);
            check("num3", num3, m_dig[2]);
            check("num4", num4, m_dig[3]);
        end
    end

    initial forever begin
        @(negedge clk);
        if (key_valid) valid_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic press(input logic [15:0] mask, input int hold);
        int t;
        pressed = mask;
        t = 0;
        while (!key_valid && t < WAIT_LIMIT) begin @(negedge clk); t++; end
        check("press_seen", key_valid, 1);
        repeat (hold) @(negedge clk);
        pressed = '0;
        t = 0;
        while (key_held && t < WAIT_LIMIT) begin @(negedge clk); t++; end
        check("release_seen", key_held, 0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_cols [5];
        int base;
        int t;
        exp_cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: idle scan, 4-clock column period
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n % 4 == 2) check("s1_col", col_n, exp_cols[n/4]);
        end
        check("s1_no_valid", valid_cnt, 0);
        check("s1_digits", {num4, num3, num2, num1}, 16'hFFFF);

        // 2: key 6 (row 1, col 2), held for 20 slots
        base = valid_cnt;
        press(16'h0040, 20 * SD);
        check("s2_pulses", valid_cnt - base, 1);
        check("s2_code", key_code, 4'h6);
        check("s2_digits", {num4, num3, num2, num1}, 16'hFFF6);

        // 3: 1..5 typed, oldest digit drops off; then clear
        press(16'h0001, 12);
        press(16'h0002, 12);
        press(16'h0004, 12);
        press(16'h0010, 12);
        press(16'h0020, 12);
        check("s3_digits", {num4, num3, num2, num1}, 16'h2345);
        press(16'h0800, 12);
        check("s3_clear_code", key_code, 4'hC);
        check("s3_cleared", {num4, num3, num2, num1}, 16'hFFFF);

        // 4: key 5 bouncing on alternate slots
        base = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (SD) @(negedge clk);
        end
        pressed = '0;
        repeat (20) @(negedge clk);
        check("s4_pulses", valid_cnt - base, 0);
        check("s4_held", key_held, 0);

        // 5: rows 0 and 2 on column 0 together, then backspace
        press(16'h0101, 12);
        check("s5_code", key_code, 4'h1);
        check("s5_digits", {num4, num3, num2, num1}, 16'hFFF1);
        press(16'h0080, 12);
        check("s5_back_code", key_code, 4'hB);
        check("s5_num1", num1, 4'hF);

        // 6: reset while key 7 is held
        pressed = 16'h0100;
        t = 0;
        while (!key_held && t < WAIT_LIMIT) begin @(negedge clk); t++; end
        check("s6_held", key_held, 1);
        repeat (4) @(negedge clk);
        check("s6_num1", num1, 4'h7);
        #2 rst_n = 1'b0;
        #1;
        check("s6_rst_held", key_held, 0);
        check("s6_rst_col", col_n, 4'b1110);
        check("s6_rst_digits", {num4, num3, num2, num1}, 16'hFFFF);
        check("s6_rst_code", key_code, 4'h0);
        pressed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = valid_cnt;
        press(16'h0400, 12);
        check("s6_pulses", valid_cnt - base, 1);
        check("s6_digits", {num4, num3, num2, num1}, 16'hFFF9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
